// File: rtl/nlc_sample_feeder.sv
// nlc_sample_feeder: buffers raw ADC samples and issues them one at a time to the NLC.
// Optional WAIT-state watchdog is built when NLC_FEEDER_WATCHDOG_EN is defined.
module nlc_sample_feeder #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   adc_valid,
    input  logic [20:0]            adc_data,
    output logic                   adc_overflow,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   srdyi,
    output logic [20:0]            x_adc,
    input  logic                   srdyo,
    input  logic [20:0]            x_lin,
    output logic                   lin_valid,
    output logic [20:0]            lin_data,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Reject parameter values the pointer wrap and watchdog cannot support.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_bad_param
        $error("nlc_sample_feeder: DEPTH must be a power of two >= 2, TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [20:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;
    logic wd_hit;

    logic srdyi_nx;
    logic busy_nx;
    logic done;
    logic drop;
    logic to_nx;

    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == LW'(DEPTH));
    assign pop        = (state == IDLE) && !fifo_empty;
    assign push       = adc_valid && (!fifo_full || pop);

`ifdef NLC_FEEDER_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wd;

    // Watchdog: cleared while issuing, counts WAIT cycles, saturates at the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd <= '0;
        end else if (state == ISSUE) begin
            wd <= '0;
        end else if ((state == WAIT) && !wd_hit) begin
            wd <= wd + WW'(1);
        end
    end

    assign wd_hit = (wd == WW'(TIMEOUT - 1));
`else
    assign wd_hit = 1'b0;
`endif

    // Sample storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= adc_data;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave the level unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + LW'(1);
            end else if (pop && !push) begin
                fifo_level <= fifo_level - LW'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: completion beats a same-cycle watchdog expiry.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (!fifo_empty) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (srdyo || wd_hit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode: next values for the registered outputs.
    always_comb begin
        srdyi_nx = 1'b0;
        busy_nx  = 1'b0;
        done     = 1'b0;
        drop     = 1'b0;
        to_nx    = 1'b0;
        unique case (1'b1)
            (state_nx == ISSUE): begin
                srdyi_nx = 1'b1;
                busy_nx  = 1'b1;
            end
            (state_nx == WAIT):  busy_nx = 1'b1;
            default:             busy_nx = 1'b0;
        endcase
        done  = (state == WAIT) && srdyo;
        to_nx = (state == WAIT) && !srdyo && wd_hit;
        drop  = adc_valid && !push;
    end

    // Output registers; nothing reaches a port combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            srdyi        <= 1'b0;
            busy         <= 1'b0;
            x_adc        <= '0;
            lin_valid    <= 1'b0;
            lin_data     <= '0;
            adc_overflow <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            srdyi        <= srdyi_nx;
            busy         <= busy_nx;
            lin_valid    <= done;
            adc_overflow <= drop;
            timeout_err  <= to_nx;
            if (pop) begin
                x_adc <= mem[rd_ptr];
            end
            if (done) begin
                lin_data <= x_lin;
            end
        end
    end

endmodule
